key_load_ctrl: RTL and testbench

//  Sequencer in front of a key-locked (obfuscated) core: takes the secret key in

---
 rtl/key_load_ctrl_pkg.sv | 25 ++
 rtl/key_load_ctrl_if.sv | 33 +++
 rtl/key_load_ctrl_shift_reg.sv | 62 ++++++
 rtl/key_load_ctrl.sv | 133 +++++++++++++
 tb/tb_key_load_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_load_ctrl_pkg.sv
// Shared types and defaults for the key load sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_load_ctrl_pkg;

    // IDLE/SHIFT accept key bits, APPLY holds the core in reset while sk settles,
    // RUN releases the core, LOCKOUT is terminal until reset.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_RUN     = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam int KEY_W_DEF         = 4;
    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int MAX_FAILS_DEF     = 3;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_load_ctrl_if.sv
// Bundle of the key-load handshake and the locked-core control outputs.
// Latency: n/a (wiring only).
// Backpressure: key_bit_ready qualifies key_bit_valid; everything else is level/pulse.
// Ports: master = key source / user side, slave = key_load_ctrl.
interface key_load_ctrl_if
    import key_load_ctrl_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int FC_W  = cnt_width(MAX_FAILS_DEF)
);
    logic             key_bit_valid;
    logic             key_bit;
    logic             key_bit_ready;
    logic             key_commit;
    logic             key_clear;
    logic             run_req;
    logic [KEY_W-1:0] sk;
    logic             core_reset;
    logic             core_enable;
    logic             key_loaded;
    logic             lockout;
    logic [FC_W-1:0]  fail_cnt;

    modport master (
        output key_bit_valid, key_bit, key_commit, key_clear, run_req,
        input  key_bit_ready, sk, core_reset, core_enable, key_loaded, lockout, fail_cnt
    );

    modport slave (
        input  key_bit_valid, key_bit, key_commit, key_clear, run_req,
        output key_bit_ready, sk, core_reset, core_enable, key_loaded, lockout, fail_cnt
    );
endinterface

// File: rtl/key_load_ctrl_shift_reg.sv
// Serial LSB-first key capture with a saturating bit counter.
// Latency: bit visible in the register one cycle after i_shift; o_nxt_* show it same cycle.
// Backpressure: o_full stops further shifts; extra strobes while full are dropped.
// Ports: i_clk/i_rst, i_shift (accepted bit strobe), i_bit, i_clear (wins over i_shift),
//        o_full, o_nxt_dat/o_nxt_cnt (register contents including this cycle's bit).
module key_shift_reg
    import key_load_ctrl_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CNT_W = cnt_width(KEY_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_full,
    output logic [KEY_W-1:0] o_nxt_dat,
    output logic [CNT_W-1:0] o_nxt_cnt
);

    logic [KEY_W-1:0] r_dat;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic [KEY_W-1:0] w_nxt_dat;
    logic [CNT_W-1:0] w_nxt_cnt;

    assign w_full = (r_cnt == CNT_W'(KEY_W));

    // Next contents are exported so a commit in the same cycle as the last bit
    // still sees the complete key.
    always_comb begin
        w_nxt_dat = r_dat;
        w_nxt_cnt = r_cnt;
        if (i_shift && !w_full) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    w_nxt_dat[i] = i_bit;
                end
            end
            w_nxt_cnt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dat <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_dat <= '0;
            r_cnt <= '0;
        end else begin
            r_dat <= w_nxt_dat;
            r_cnt <= w_nxt_cnt;
        end
    end

    assign o_full    = w_full;
    assign o_nxt_dat = w_nxt_dat;
    assign o_nxt_cnt = w_nxt_cnt;

endmodule

// File: rtl/key_load_ctrl.sv
// Key load sequencer: serial key in, settle window, core reset release, fail lockout.
// Latency: sk one cycle after a good commit; core_reset drops SETTLE_CYCLES later.
// Backpressure: key_bit_ready high only in IDLE/SHIFT with room; from registers only.
// Ports: i_clk, i_rst (async, active-high), bus (slave side of key_load_ctrl_if).
module key_load_ctrl
    import key_load_ctrl_pkg::*;
#(
    parameter int KEY_W         = KEY_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MAX_FAILS     = MAX_FAILS_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    key_load_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(KEY_W);
    localparam int FC_W  = cnt_width(MAX_FAILS);
    localparam int SW    = cnt_width(SETTLE_CYCLES);

    state_t           r_state;
    logic [KEY_W-1:0] r_sk;
    logic             r_core_reset;
    logic             r_core_enable;
    logic             r_key_loaded;
    logic             r_lockout;
    logic [FC_W-1:0]  r_fail_cnt;
    logic [SW-1:0]    r_settle;

    logic             w_load;
    logic             w_ready;
    logic             w_accept;
    logic             w_sr_clear;
    logic             w_full;
    logic             w_good;
    logic [KEY_W-1:0] w_nxt_dat;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [FC_W-1:0]  w_fail_nxt;

    assign w_load  = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
    assign w_ready = w_load && !w_full;
    // A bit offered alongside key_clear is dropped: the clear wins.
    assign w_accept   = bus.key_bit_valid && w_ready && !bus.key_clear;
    // Commit always empties the capture register so no partial or stale key lingers.
    assign w_sr_clear = w_load && (bus.key_clear || bus.key_commit);
    assign w_good     = (w_nxt_cnt == CNT_W'(KEY_W));
    assign w_fail_nxt = r_fail_cnt + FC_W'(1);

    key_shift_reg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_shift   (w_accept),
        .i_bit     (bus.key_bit),
        .i_clear   (w_sr_clear),
        .o_full    (w_full),
        .o_nxt_dat (w_nxt_dat),
        .o_nxt_cnt (w_nxt_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_sk          <= '0;
            r_core_reset  <= 1'b1;
            r_core_enable <= 1'b0;
            r_key_loaded  <= 1'b0;
            r_lockout     <= 1'b0;
            r_fail_cnt    <= '0;
            r_settle      <= '0;
        end else if ((r_state != ST_LOCKOUT) && bus.key_clear) begin
            r_state       <= ST_IDLE;
            r_sk          <= '0;
            r_core_reset  <= 1'b1;
            r_core_enable <= 1'b0;
            r_key_loaded  <= 1'b0;
            r_settle      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_SHIFT: begin
                    if (bus.key_commit) begin
                        if (w_good) begin
                            r_state    <= ST_APPLY;
                            r_sk       <= w_nxt_dat;
                            r_fail_cnt <= '0;
                            r_settle   <= '0;
                        end else begin
                            r_fail_cnt <= w_fail_nxt;
                            if (w_fail_nxt == FC_W'(MAX_FAILS)) begin
                                r_state   <= ST_LOCKOUT;
                                r_lockout <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else if (w_accept) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_APPLY: begin
                    // sk has been stable for r_settle+1 cycles at this point.
                    if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_key_loaded <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                ST_RUN: begin
                    r_core_enable <= bus.run_req;
                end
                ST_LOCKOUT: begin
                    r_state <= ST_LOCKOUT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.key_bit_ready = w_ready;
    assign bus.sk            = r_sk;
    assign bus.core_reset    = r_core_reset;
    assign bus.core_enable   = r_core_enable;
    assign bus.key_loaded    = r_key_loaded;
    assign bus.lockout       = r_lockout;
    assign bus.fail_cnt      = r_fail_cnt;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Randomized and directed stimulus against a queue-based reference model with a scoreboard.
// Latency: expectations are queued per clock and compared one cycle later.
// Backpressure: ready is predicted by the model from its own bit count.
module tb_key_load_ctrl;

    localparam int KEY_W     = 4;
    localparam int SETTLE    = 2;
    localparam int MAX_FAILS = 3;
    localparam int FC_W      = 2;

    localparam int PH_LOAD  = 0;
    localparam int PH_APPLY = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_LOCK  = 3;

    typedef struct packed {
        logic [KEY_W-1:0] sk;
        logic             cr;
        logic             ce;
        logic             kl;
        logic             lo;
        logic [FC_W-1:0]  fc;
        logic             rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_load_ctrl_if #(.KEY_W(KEY_W), .FC_W(FC_W)) bus ();

    key_load_ctrl #(
        .KEY_W         (KEY_W),
        .SETTLE_CYCLES (SETTLE),
        .MAX_FAILS     (MAX_FAILS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model: a loading phase with a list of received bits, an apply
    // countdown, a run phase and a terminal lock.
    int ph;
    int bits[$];
    int key_val;
    int wait_n;
    int fails;
    bit cen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string tag, input exp_t e);
        chk({tag, ".sk"},          int'(bus.sk),            int'(e.sk));
        chk({tag, ".core_reset"},  int'(bus.core_reset),    int'(e.cr));
        chk({tag, ".core_enable"}, int'(bus.core_enable),   int'(e.ce));
        chk({tag, ".key_loaded"},  int'(bus.key_loaded),    int'(e.kl));
        chk({tag, ".lockout"},     int'(bus.lockout),       int'(e.lo));
        chk({tag, ".fail_cnt"},    int'(bus.fail_cnt),      int'(e.fc));
        chk({tag, ".ready"},       int'(bus.key_bit_ready), int'(e.rdy));
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.sk  = (ph == PH_APPLY || ph == PH_RUN) ? KEY_W'(key_val) : '0;
        e.cr  = (ph != PH_RUN);
        e.ce  = (ph == PH_RUN) && cen;
        e.kl  = (ph == PH_RUN);
        e.lo  = (ph == PH_LOCK);
        e.fc  = FC_W'(fails);
        e.rdy = (ph == PH_LOAD) && (bits.size() < KEY_W);
        return e;
    endfunction

    task automatic model_reset();
        ph      = PH_LOAD;
        bits.delete();
        key_val = 0;
        wait_n  = 0;
        fails   = 0;
        cen     = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c, input bit clr, input bit rr);
        if (ph == PH_LOCK) return;
        if (clr) begin
            bits.delete();
            ph  = PH_LOAD;
            cen = 1'b0;
            return;
        end
        case (ph)
            PH_LOAD: begin
                if (v && bits.size() < KEY_W) bits.push_back(int'(b));
                if (c) begin
                    if (bits.size() == KEY_W) begin
                        key_val = 0;
                        foreach (bits[i]) key_val += bits[i] << i;
                        fails  = 0;
                        ph     = PH_APPLY;
                        wait_n = SETTLE;
                    end else begin
                        fails++;
                        if (fails == MAX_FAILS) ph = PH_LOCK;
                    end
                    bits.delete();
                end
            end
            PH_APPLY: begin
                wait_n--;
                if (wait_n == 0) begin
                    ph  = PH_RUN;
                    cen = 1'b0;
                end
            end
            PH_RUN: cen = rr;
            default: ;
        endcase
    endtask

    // One clock of stimulus: drive on the falling edge, queue the post-edge expectation.
    task automatic cycle(input bit v, input bit b, input bit c, input bit clr, input bit rr);
        @(negedge clk);
        rst               = 1'b0;
        bus.key_bit_valid = v;
        bus.key_bit       = b;
        bus.key_commit    = c;
        bus.key_clear     = clr;
        bus.run_req       = rr;
        model_step(v, b, c, clr, rr);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic shift_bits(input int n, input int val);
        for (int i = 0; i < n; i++) cycle(1, ((val >> i) & 1) != 0, 0, 0, 0);
    endtask

    // Assert reset between edges and require reset values before the next edge.
    task automatic do_reset(input string tag);
        exp_t e;
        @(posedge clk);
        #3;
        rst               = 1'b1;
        bus.key_bit_valid = 1'b0;
        bus.key_bit       = 1'b0;
        bus.key_commit    = 1'b0;
        bus.key_clear     = 1'b0;
        bus.run_req       = 1'b0;
        #1;
        model_reset();
        e = model_out();
        check_bus(tag, e);
    endtask

    task automatic post_edge_chk(input string name, input int act_sel, input int exp);
        @(posedge clk);
        #2;
        case (act_sel)
            0: chk(name, int'(bus.sk), exp);
            1: chk(name, int'(bus.core_reset), exp);
            2: chk(name, int'(bus.lockout), exp);
            default: chk(name, int'(bus.fail_cnt), exp);
        endcase
    endtask

    // Scoreboard monitor: every queued expectation is compared just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bus("cyc", e);
            end
        end
    end

    initial begin
        exp_t e;
        bus.key_bit_valid = 1'b0;
        bus.key_bit       = 1'b0;
        bus.key_commit    = 1'b0;
        bus.key_clear     = 1'b0;
        bus.run_req       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        e = model_out();
        check_bus("reset", e);

        // Good load of 1,0,1,1 LSB first.
        shift_bits(4, 4'b1101);
        cycle(0, 0, 1, 0, 0);
        post_edge_chk("sk_after_commit", 0, 4'hD);
        idle(1);
        cycle(0, 0, 0, 0, 0);
        post_edge_chk("core_reset_released", 1, 0);

        // RUN: enable follows run_req, bits and commit ignored.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        idle(1);

        // Three short commits lead to lockout; clear and bits then ignored.
        for (int k = 0; k < 3; k++) begin
            shift_bits(3, 3'b101);
            cycle(0, 0, 1, 0, 0);
        end
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 1);
        cycle(1, 1, 0, 0, 0);
        post_edge_chk("lockout_held", 2, 1);
        do_reset("rst_lock");

        // Last bit with commit in the same cycle, then clear during APPLY.
        shift_bits(3, 3'b011);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        idle(1);

        // Full register refuses a fifth bit; committed key is the first four.
        shift_bits(4, 4'b0110);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        post_edge_chk("sk_full_no_extra", 0, 4'h6);
        idle(3);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0);
        idle(1);

        // Async reset mid-SHIFT and mid-RUN.
        shift_bits(2, 2'b11);
        do_reset("rst_shift");
        shift_bits(4, 4'b1010);
        cycle(0, 0, 1, 0, 0);
        idle(4);
        cycle(0, 0, 0, 0, 1);
        do_reset("rst_run");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit v, b, c, clr, rr;
            if ((ph == PH_LOCK && $urandom_range(0, 19) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset("rst_rand");
            end
            v   = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 39) == 0);
            rr  = 1'($urandom_range(0, 1));
            cycle(v, b, c, clr, rr);
        end

        idle(2);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
